// File: rtl/fm_sb_playback.sv
// fm_sb_playback
// ---------------------------------------------------------------------------
// Playback reader for one fast-monitoring spy buffer. It reads stored words
// from SB_MEM and re-injects them into the pipeline as a data/valid stream.
// The word at address 0..last is replayed once (single-shot), or repeatedly
// (loop), one read per cycle with no backpressure.
//
// Optional build macro: FM_SB_PB_GAP_EN adds pb_gap_i, a per-playback idle
// gap (in cycles) inserted after every issued read.
//
// Ports:
//   clk, rst          pipeline clock, asynchronous active-high reset
//   pb_mode_i         00 off, 01 single-shot, 10 loop, 11 same as off
//   pb_start_i        single-cycle start pulse (honoured only in IDLE)
//   pb_last_addr_i    last address to replay, sampled on accepted start
//   pb_gap_i          (FM_SB_PB_GAP_EN only) idle cycles between reads
//   mem_rd_en_o       memory read enable
//   mem_rd_addr_o     memory read address
//   mem_rd_data_i     memory read data, valid RD_LAT cycles after the enable
//   pb_data_o         replayed word, holds its value while pb_vld_o is low
//   pb_vld_o          replayed word valid
//   pb_busy_o         high while running or draining
//   pb_done_o         one-cycle pulse once the last word has left the block
//   pb_loop_cnt_o     completed loop passes, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module fm_sb_playback #(
    parameter int DW     = 256,
    parameter int AW     = 10,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pb_mode_i,
    input  logic          pb_start_i,
    input  logic [AW-1:0] pb_last_addr_i,
`ifdef FM_SB_PB_GAP_EN
    input  logic [7:0]    pb_gap_i,
`endif
    output logic          mem_rd_en_o,
    output logic [AW-1:0] mem_rd_addr_o,
    input  logic [DW-1:0] mem_rd_data_i,
    output logic [DW-1:0] pb_data_o,
    output logic          pb_vld_o,
    output logic          pb_busy_o,
    output logic          pb_done_o,
    output logic [15:0]   pb_loop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     last_q, last_d;
    logic [15:0]       loop_q, loop_d;
    logic [RD_LAT-1:0] vsr_q, vsr_d;
    logic              vld_q;
    logic [DW-1:0]     data_q;
    logic              rd_en;
    logic              done;
    logic              mode_on;
`ifdef FM_SB_PB_GAP_EN
    logic [7:0]        gap_q, gap_d;
    logic [7:0]        gcnt_q, gcnt_d;
`endif

    assign mode_on = (pb_mode_i == 2'b01) || (pb_mode_i == 2'b10);

    // Next-state logic. Mode is re-evaluated every RUN cycle so that turning
    // playback off stops reads at once; switching between single-shot and
    // loop only matters when the last address is reached.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        loop_d  = loop_q;
        rd_en   = 1'b0;
        done    = 1'b0;
`ifdef FM_SB_PB_GAP_EN
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pb_start_i && mode_on) begin
                    last_d  = pb_last_addr_i;
                    addr_d  = '0;
                    loop_d  = 16'd0;
                    state_d = RUN;
`ifdef FM_SB_PB_GAP_EN
                    gap_d   = pb_gap_i;
                    gcnt_d  = 8'd0;
`endif
                end
            end
            RUN: begin
                if (!mode_on) begin
                    state_d = DRAIN;
                end
`ifdef FM_SB_PB_GAP_EN
                else if (gcnt_q != 8'd0) begin
                    gcnt_d = gcnt_q - 8'd1;
                end
`endif
                else begin
                    rd_en = 1'b1;
`ifdef FM_SB_PB_GAP_EN
                    gcnt_d = gap_q;
`endif
                    // Wrap to 0 only through the loop rule, so a full-memory
                    // last address never relies on counter overflow.
                    if (addr_q < last_q) begin
                        addr_d = addr_q + 1'b1;
                    end else if (pb_mode_i == 2'b01) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = '0;
                        if (loop_q != 16'hFFFF) begin
                            loop_d = loop_q + 16'd1;
                        end
                    end
                end
            end
            DRAIN: begin
                if ((vsr_q == '0) && !vld_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Valid shift register: stage i holds the enable issued i+1 cycles ago,
    // so the top stage lines up with the matching memory read data.
    always_comb begin
        vsr_d    = vsr_q;
        vsr_d[0] = rd_en;
        for (int i = 1; i < RD_LAT; i++) begin
            vsr_d[i] = vsr_q[i-1];
        end
    end

    // State, address and output registers; reset discards in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            loop_q  <= 16'd0;
            vsr_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
`ifdef FM_SB_PB_GAP_EN
            gap_q   <= 8'd0;
            gcnt_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            vsr_q   <= vsr_d;
            vld_q   <= vsr_q[RD_LAT-1];
            if (vsr_q[RD_LAT-1]) begin
                data_q <= mem_rd_data_i;
            end
`ifdef FM_SB_PB_GAP_EN
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
`endif
        end
    end

    assign mem_rd_en_o   = rd_en;
    assign mem_rd_addr_o = addr_q;
    assign pb_data_o     = data_q;
    assign pb_vld_o      = vld_q;
    assign pb_busy_o     = (state_q != IDLE);
    assign pb_done_o     = done;
    assign pb_loop_cnt_o = loop_q;

endmodule

// File: tb/tb_fm_sb_playback.sv
// tb_fm_sb_playback
// ---------------------------------------------------------------------------
// Bench for fm_sb_playback with a small SB_MEM model (word k = k + 0x100,
// two-cycle read pipeline). A transaction-level model predicts, for every
// cycle, which read is issued and when its word must come out, and a compare
// process checks all DUT outputs against it. Directed scenarios add literal
// expectations for single-shot, loop, ignored starts, single word, reset
// mid-run, full memory, saturation and (with FM_SB_PB_GAP_EN) read gaps.
// ---------------------------------------------------------------------------
module tb_fm_sb_playback;

    localparam int DW     = 32;
    localparam int AW     = 4;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    pbMode = 2'b00;
    logic          pbStart = 1'b0;
    logic [AW-1:0] pbLastAddr = '0;
`ifdef FM_SB_PB_GAP_EN
    logic [7:0]    pbGap = 8'd0;
`endif
    logic          memRdEn;
    logic [AW-1:0] memRdAddr;
    logic [DW-1:0] memRdData;
    logic [DW-1:0] pbData;
    logic          pbVld;
    logic          pbBusy;
    logic          pbDone;
    logic [15:0]   pbLoopCnt;

    int total = 0;
    int bad   = 0;

    fm_sb_playback #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .pb_mode_i     (pbMode),
        .pb_start_i    (pbStart),
        .pb_last_addr_i(pbLastAddr),
`ifdef FM_SB_PB_GAP_EN
        .pb_gap_i      (pbGap),
`endif
        .mem_rd_en_o   (memRdEn),
        .mem_rd_addr_o (memRdAddr),
        .mem_rd_data_i (memRdData),
        .pb_data_o     (pbData),
        .pb_vld_o      (pbVld),
        .pb_busy_o     (pbBusy),
        .pb_done_o     (pbDone),
        .pb_loop_cnt_o (pbLoopCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return 32'h100 + 32'(a);
    endfunction

    // Memory with a two-stage read pipeline; non-read cycles return junk.
    logic [DW-1:0] memP1 = '0;
    logic [DW-1:0] memP2 = '0;
    always @(posedge clk) begin
        memP1 <= memRdEn ? memWord(memRdAddr) : 32'hDEADBEEF;
        memP2 <= memP1;
    end
    assign memRdData = memP2;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: a read issued in cycle c must produce its
    // word at cycle c+RD_LAT+1; playback finishes the cycle after draining
    // starts, or once the last issued word has left, whichever is later.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } outEnt_t;

    outEnt_t       expQ[$];
    int            cyc = 0;
    bit            mRun = 0;
    bit            mDrain = 0;
    logic [AW-1:0] mAddr = '0;
    logic [AW-1:0] mLast = '0;
    logic [15:0]   mLoop = 16'd0;
    logic [DW-1:0] mLastData = '0;
    int            lastRd = -100;
    int            mDoneAt = 0;
    int            mGap = 0;
    int            gapLeft = 0;

    function automatic bit modeOn();
        return (pbMode == 2'b01) || (pbMode == 2'b10);
    endfunction

    function automatic int laterOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            expQ.delete();
            mRun = 0;
            mDrain = 0;
            mAddr = '0;
            mLoop = 16'd0;
            mLastData = '0;
            gapLeft = 0;
        end else begin
            if (expQ.size() > 0 && expQ[0].due == cyc) begin
                mLastData = expQ[0].data;
                void'(expQ.pop_front());
            end
            if (mDrain) begin
                if (cyc == mDoneAt) mDrain = 0;
            end else if (mRun) begin
                if (!modeOn()) begin
                    mRun = 0;
                    mDrain = 1;
                    mDoneAt = laterOf(cyc + 1, lastRd + RD_LAT + 2);
                end else if (gapLeft > 0) begin
                    gapLeft--;
                end else begin
                    expQ.push_back('{due: cyc + RD_LAT + 1, data: memWord(mAddr)});
                    lastRd = cyc;
                    gapLeft = mGap;
                    if (mAddr < mLast) begin
                        mAddr = mAddr + 1'b1;
                    end else if (pbMode == 2'b01) begin
                        mRun = 0;
                        mDrain = 1;
                        mDoneAt = laterOf(cyc + 1, lastRd + RD_LAT + 2);
                    end else begin
                        mAddr = '0;
                        if (mLoop != 16'hFFFF) mLoop = mLoop + 16'd1;
                    end
                end
            end else if (pbStart && modeOn()) begin
                mRun = 1;
                mAddr = '0;
                mLast = pbLastAddr;
                mLoop = 16'd0;
                gapLeft = 0;
`ifdef FM_SB_PB_GAP_EN
                mGap = int'(pbGap);
`else
                mGap = 0;
`endif
            end
        end
        cyc++;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        bit            eVld;
        bit            eRd;
        logic [DW-1:0] eData;
        if (rst) begin
            checkOutput("rst_vld", pbVld, 0);
            checkOutput("rst_data", pbData, 0);
            checkOutput("rst_rden", memRdEn, 0);
            checkOutput("rst_busy", pbBusy, 0);
            checkOutput("rst_done", pbDone, 0);
            checkOutput("rst_loop", pbLoopCnt, 0);
        end else begin
            eVld  = (expQ.size() > 0) && (expQ[0].due == cyc);
            eData = eVld ? expQ[0].data : mLastData;
            eRd   = mRun && modeOn() && (gapLeft == 0);
            checkOutput("cmp_vld", pbVld, eVld);
            checkOutput("cmp_data", pbData, eData);
            checkOutput("cmp_rden", memRdEn, eRd);
            if (eRd) checkOutput("cmp_addr", memRdAddr, mAddr);
            checkOutput("cmp_busy", pbBusy, mRun || mDrain);
            checkOutput("cmp_done", pbDone, mDrain && (cyc == mDoneAt));
            checkOutput("cmp_loop", pbLoopCnt, mLoop);
        end
    end

    // Logs used by the literal scenario checks.
    logic [DW-1:0] vldLog[$];
    int            rdLog[$];
    int            doneCount = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (pbVld) vldLog.push_back(pbData);
            if (memRdEn) rdLog.push_back(cyc);
            if (pbDone) doneCount++;
        end
    end

    task automatic clearLogs();
        vldLog.delete();
        rdLog.delete();
        doneCount = 0;
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic start, input logic [AW-1:0] last);
        @(posedge clk);
        #1;
        pbMode = mode;
        pbStart = start;
        pbLastAddr = last;
    endtask

    task automatic waitDone(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (pbDone) seen = 1;
        end
        checkOutput(name, seen, 1);
        #1;
    endtask

    initial begin
        #1;
        checkOutput("reset_vld", pbVld, 0);
        checkOutput("reset_busy", pbBusy, 0);
        checkOutput("reset_loop", pbLoopCnt, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single-shot, last=3: words at cycles 4..7, done at 8, idle at 9.
        clearLogs();
        applyStimulus(2'b01, 1'b1, 4'd3);
        applyStimulus(2'b01, 1'b0, 4'd3);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 3) checkOutput("ss_vld_c3", pbVld, 0);
            if (k >= 4 && k <= 7) begin
                checkOutput("ss_vld", pbVld, 1);
                checkOutput("ss_data", pbData, 32'h100 + 32'(k - 4));
            end
            if (k == 8) checkOutput("ss_done_c8", pbDone, 1);
            if (k == 9) checkOutput("ss_busy_c9", pbBusy, 0);
        end
        checkOutput("ss_loop", pbLoopCnt, 0);
        checkOutput("ss_done_cnt", doneCount, 1);

        // Loop, last=1, stopped after 6 reads.
        clearLogs();
        applyStimulus(2'b10, 1'b1, 4'd1);
        repeat (6) applyStimulus(2'b10, 1'b0, 4'd1);
        applyStimulus(2'b00, 1'b0, 4'd1);
        waitDone("loop_done", 10);
        checkOutput("loop_words", vldLog.size(), 6);
        for (int i = 0; i < vldLog.size(); i++) checkOutput("loop_data", vldLog[i], 32'h100 + 32'(i % 2));
        checkOutput("loop_cnt", pbLoopCnt, 3);

        // Starts with mode 00/11 are ignored.
        clearLogs();
        applyStimulus(2'b00, 1'b1, 4'd3);
        applyStimulus(2'b00, 1'b0, 4'd3);
        applyStimulus(2'b11, 1'b1, 4'd3);
        repeat (3) applyStimulus(2'b11, 1'b0, 4'd3);
        checkOutput("ign_reads", rdLog.size(), 0);
        checkOutput("ign_busy", pbBusy, 0);

        // A second start during RUN does not restart the address.
        clearLogs();
        applyStimulus(2'b01, 1'b1, 4'd7);
        applyStimulus(2'b01, 1'b0, 4'd7);
        applyStimulus(2'b01, 1'b0, 4'd7);
        applyStimulus(2'b01, 1'b1, 4'd2);
        applyStimulus(2'b01, 1'b0, 4'd2);
        waitDone("restart_done", 30);
        checkOutput("restart_words", vldLog.size(), 8);
        for (int i = 0; i < vldLog.size(); i++) checkOutput("restart_data", vldLog[i], 32'h100 + 32'(i));

        // Single word.
        clearLogs();
        applyStimulus(2'b01, 1'b1, 4'd0);
        applyStimulus(2'b01, 1'b0, 4'd0);
        waitDone("single_done", 10);
        checkOutput("single_words", vldLog.size(), 1);
        if (vldLog.size() > 0) checkOutput("single_data", vldLog[0], 32'h100);

        // Asynchronous reset with reads in flight.
        clearLogs();
        applyStimulus(2'b10, 1'b1, 4'd5);
        repeat (5) applyStimulus(2'b10, 1'b0, 4'd5);
        checkOutput("rstmid_vld_before", pbVld, 1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_vld", pbVld, 0);
        checkOutput("rstmid_busy", pbBusy, 0);
        checkOutput("rstmid_rden", memRdEn, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) applyStimulus(2'b00, 1'b0, 4'd5);
        checkOutput("rstmid_no_done", doneCount, 0);
        clearLogs();
        applyStimulus(2'b01, 1'b1, 4'd2);
        applyStimulus(2'b01, 1'b0, 4'd2);
        waitDone("rstmid_replay_done", 10);
        checkOutput("rstmid_words", vldLog.size(), 3);
        if (vldLog.size() > 0) checkOutput("rstmid_first", vldLog[0], 32'h100);

        // Full memory: wrap from 15 to 0 through the loop rule.
        clearLogs();
        applyStimulus(2'b10, 1'b1, 4'd15);
        repeat (20) applyStimulus(2'b10, 1'b0, 4'd15);
        applyStimulus(2'b00, 1'b0, 4'd15);
        waitDone("full_done", 10);
        checkOutput("full_words", vldLog.size(), 20);
        if (vldLog.size() == 20) begin
            checkOutput("full_d15", vldLog[15], 32'h10F);
            checkOutput("full_d16", vldLog[16], 32'h100);
        end
        checkOutput("full_loop", pbLoopCnt, 1);

`ifdef FM_SB_PB_GAP_EN
        // Gap of 2: one read every third cycle.
        clearLogs();
        pbGap = 8'd2;
        applyStimulus(2'b01, 1'b1, 4'd3);
        applyStimulus(2'b01, 1'b0, 4'd3);
        waitDone("gap_done", 30);
        checkOutput("gap_reads", rdLog.size(), 4);
        for (int i = 1; i < rdLog.size(); i++) checkOutput("gap_spacing", rdLog[i] - rdLog[i-1], 3);
        pbGap = 8'd0;
`endif

        // Loop counter saturation with a single-word loop.
        applyStimulus(2'b10, 1'b1, 4'd0);
        applyStimulus(2'b10, 1'b0, 4'd0);
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("sat_loop", pbLoopCnt, 16'hFFFF);
        applyStimulus(2'b00, 1'b0, 4'd0);
        waitDone("sat_done", 10);
        checkOutput("sat_loop_hold", pbLoopCnt, 16'hFFFF);
        clearLogs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
